led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED pattern generator for the board LED banks, driven from CLOCK_50. A programmable prescaler sets a slow or fast step rate, and a mode selector picks one of four patterns: blink-all, chase, bounce or binary count. A pause control freezes the pattern. The top level maps KEY/SW onto the control inputs and drives LEDR/LEDG from the outputs; it also inverts the active-low KEYs.

Parameters:
N_LEDS, 8, number of LED outputs; N_LEDS >= 2
SLOW_DIV, 50000000, clock cycles per pattern step when speed=0; SLOW_DIV >= FAST_DIV
FAST_DIV, 5000000, clock cycles per pattern step when speed=1; FAST_DIV >= 2

Ports:
CLOCK_50  in  1  system clock; all state is on its rising edge
RESET  in  1  asynchronous, active-high reset
mode  in  2  pattern select: 00 blink, 01 chase, 10 bounce, 11 count
speed  in  1  0 = SLOW_DIV period, 1 = FAST_DIV period
pause  in  1  1 = freeze the prescaler and the pattern
leds  out  N_LEDS  pattern output, registered
step  out  1  one-cycle pulse on every cycle in which leds advances

Behaviour:
- Interface: one clock, CLOCK_50. RESET is asynchronous and active-high.
- While RESET is asserted: leds=0, step=0, prescaler cnt=0, bounce direction=up, mode_q=00, init flag=1.
- Prescaler
  - cnt has width $clog2(SLOW_DIV).
  - div = speed ? FAST_DIV : SLOW_DIV.
  - If cnt >= div-1: cnt <= 0 and an internal tick fires. Otherwise cnt <= cnt+1.
  - The >= comparison covers a switch from slow to fast while cnt is above FAST_DIV-1.
  - A change of speed (compared with the registered speed_q) forces cnt <= 0 and suppresses the tick that cycle.
- Pause
  - While pause=1: cnt, leds, the bounce direction and step=0 all hold.
  - The mode-change load below still applies during pause.
- Load event: occurs when init=1 or mode != mode_q.
  - leds <= the start pattern of the new mode, cnt <= 0, direction <= up, mode_q <= mode, init <= 0, step <= 0.
  - The load takes priority over a tick in the same cycle, and the tick is dropped.
  - Start patterns: blink = all zeros; chase = 1 in bit 0; bounce = 1 in bit 0; count = 0.
  - The first cycle after RESET is released is therefore always a load. The first tick lands div cycles after the load.
- On a tick (not paused, no load): step <= 1 and leds advances by mode.
  - blink: leds <= ~leds, so the whole bank toggles between all-0 and all-1.
  - chase: rotate left by 1; bit N_LEDS-1 wraps to bit 0.
  - bounce, direction up: shift left. When the shift places the 1 in bit N_LEDS-1, direction <= down.
  - bounce, direction down: shift right. When the shift places the 1 in bit 0, direction <= up.
  - bounce sequence for N_LEDS=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. The end LEDs are lit for a single step each.
  - count: leds <= leds+1, modulo 2^N_LEDS; all-ones wraps to 0.
- Output timing:
  - leds updates one cycle after the tick condition is met in cnt.
  - step is high in exactly the same cycle that the new leds value first appears.
- RESET asserted mid-pattern clears everything asynchronously. After release, the start pattern of the current mode is reloaded.
- No combinational path from any input to any output.

Test Plan:
(All scenarios use N_LEDS=4, SLOW_DIV=6, FAST_DIV=3.)
- Reset then mode=01, speed=0, pause=0.
  - Required: leds=0001 on the first cycle after release.
  - Then 0010, 0100, 1000, 0001, with exactly 6 cycles between step pulses and one step pulse per change.
- mode=10, speed=1.
  - Required sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, with 3 cycles per step.
- mode=11, speed=1, run 17 ticks.
  - Required: leds counts 0000 to 1111, then wraps to 0000, ending at 0001.
- mode=00, speed=0; switch to speed=1 when cnt=4.
  - Required: no tick on the switch cycle, cnt=0.
  - The next toggle (0000 to 1111) comes 3 cycles later.
- Pause and mode change, starting in chase at leds=0100.
  - pause=1 for 20 cycles: required leds holds at 0100 and step stays 0.
  - Change mode to 11 while paused: required leds=0000 on the next cycle.
  - Release pause: required leds=0001 after 3 (fast) or 6 (slow) cycles.
- Mode change on the exact cycle a tick is due, then a reset.
  - Required: leds loads the new start pattern, step=0, and the tick is dropped.
  - Then assert RESET asynchronously between clock edges: leds=0 and step=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick drives blink, chase,
// bounce or binary-count patterns onto an LED bank.
// Ports: CLOCK_50 clock, RESET async active-high reset,
//        mode pattern select (00 blink, 01 chase, 10 bounce, 11 count),
//        speed (0 slow, 1 fast), pause (freeze),
//        leds registered pattern, step one-cycle advance pulse.
module led_pattern_gen #(
   parameter int N_LEDS   = 8,
   parameter int SLOW_DIV = 50000000,
   parameter int FAST_DIV = 5000000
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic [1:0]        mode,
   input  logic              speed,
   input  logic              pause,
   output logic [N_LEDS-1:0] leds,
   output logic              step
);

   localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_DIV - 1);
   localparam logic [CW-1:0] FAST_M1 = CW'(FAST_DIV - 1);

   typedef enum logic [1:0] {
      M_BLINK  = 2'b00,
      M_CHASE  = 2'b01,
      M_BOUNCE = 2'b10,
      M_COUNT  = 2'b11
   } mode_t;

   logic [CW-1:0]     cnt;
   logic [CW-1:0]     div_m1;
   logic              speed_q;
   logic              dir_up;
   logic              dir_nxt;
   logic              init;
   mode_t             mode_q;
   logic              load;
   logic [N_LEDS-1:0] nxt;
   logic [N_LEDS-1:0] start_pat;

   assign div_m1 = speed ? FAST_M1 : SLOW_M1;
   assign load   = init || (mode != mode_q);

   always_comb begin
      start_pat = '0;
      if (mode == M_CHASE || mode == M_BOUNCE)
         start_pat = N_LEDS'(1);
   end

   // Next pattern for the current (already loaded) mode.
   always_comb begin
      nxt     = leds;
      dir_nxt = dir_up;
      unique case (mode_q)
         M_BLINK: nxt = ~leds;
         M_CHASE: nxt = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
         M_BOUNCE: begin
            if (dir_up) begin
               nxt = leds << 1;
               if (nxt[N_LEDS-1]) dir_nxt = 1'b0;
            end else begin
               nxt = leds >> 1;
               if (nxt[0]) dir_nxt = 1'b1;
            end
         end
         M_COUNT: nxt = leds + N_LEDS'(1);
      endcase
   end

   // Priority: load > pause > speed change > tick > count.
   // The >= compare recovers when cnt sits above a newly shortened period.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         leds    <= '0;
         step    <= 1'b0;
         cnt     <= '0;
         dir_up  <= 1'b1;
         mode_q  <= M_BLINK;
         init    <= 1'b1;
         speed_q <= 1'b0;
      end else begin
         speed_q <= speed;
         if (load) begin
            leds   <= start_pat;
            cnt    <= '0;
            dir_up <= 1'b1;
            mode_q <= mode_t'(mode);
            init   <= 1'b0;
            step   <= 1'b0;
         end else if (pause) begin
            step <= 1'b0;
         end else if (speed != speed_q) begin
            cnt  <= '0;
            step <= 1'b0;
         end else if (cnt >= div_m1) begin
            cnt    <= '0;
            step   <= 1'b1;
            leds   <= nxt;
            dir_up <= dir_nxt;
         end else begin
            cnt  <= cnt + CW'(1);
            step <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen with
// N_LEDS=4, SLOW_DIV=6, FAST_DIV=3.
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       speed;
   logic       pause;
   logic [3:0] leds;
   logic       step;

   int pass_cnt = 0;
   int total_cnt = 0;

   led_pattern_gen #(
      .N_LEDS(4),
      .SLOW_DIV(6),
      .FAST_DIV(3)
   ) dut (
      .CLOCK_50(clk),
      .RESET(rst),
      .mode(mode),
      .speed(speed),
      .pause(pause),
      .leds(leds),
      .step(step)
   );

   always #5 clk = ~clk;

   // Advance to the negedge where step is seen high; n = cycles taken.
   task automatic wait_step(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step && n < 20);
   endtask

   task automatic test_reset;
      rst = 1'b1; mode = 2'b01; speed = 1'b0; pause = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0000 || step !== 1'b0)
         $display("FAIL reset_state leds=%b step=%b want 0000/0", leds, step);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0001 || step !== 1'b0)
         $display("FAIL first_load leds=%b step=%b want 0001/0", leds, step);
      else pass_cnt++;
   endtask

   task automatic test_chase;
      logic [3:0] exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int n;
      for (int i = 0; i < 4; i++) begin
         wait_step(n);
         total_cnt++;
         if (n !== 6 || leds !== exp[i])
            $display("FAIL chase_%0d leds=%b gap=%0d want %b gap 6",
                     i, leds, n, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_bounce;
      logic [3:0] exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0010};
      int n;
      mode = 2'b10; speed = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0001 || step !== 1'b0)
         $display("FAIL bounce_load leds=%b step=%b want 0001/0", leds, step);
      else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
         wait_step(n);
         total_cnt++;
         if (n !== 3 || leds !== exp[i])
            $display("FAIL bounce_%0d leds=%b gap=%0d want %b gap 3",
                     i, leds, n, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_count;
      int n;
      logic [3:0] e;
      mode = 2'b11; speed = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0000)
         $display("FAIL count_load leds=%b want 0000", leds);
      else pass_cnt++;
      e = 4'b0000;
      for (int i = 0; i < 17; i++) begin
         e = e + 4'd1;
         wait_step(n);
         total_cnt++;
         if (n !== 3 || leds !== e)
            $display("FAIL count_%0d leds=%b gap=%0d want %b gap 3",
                     i, leds, n, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_speed_switch;
      int n;
      mode = 2'b00; speed = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0000 || dut.cnt !== 3'd0)
         $display("FAIL blink_load leds=%b cnt=%0d want 0000/0",
                  leds, dut.cnt);
      else pass_cnt++;
      repeat (4) @(negedge clk);
      total_cnt++;
      if (dut.cnt !== 3'd4 || step !== 1'b0)
         $display("FAIL pre_switch cnt=%0d step=%b want 4/0", dut.cnt, step);
      else pass_cnt++;
      speed = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (step !== 1'b0 || dut.cnt !== 3'd0 || leds !== 4'b0000)
         $display("FAIL switch_cycle step=%b cnt=%0d leds=%b want 0/0/0000",
                  step, dut.cnt, leds);
      else pass_cnt++;
      wait_step(n);
      total_cnt++;
      if (n !== 3 || leds !== 4'b1111)
         $display("FAIL post_switch leds=%b gap=%0d want 1111 gap 3",
                  leds, n);
      else pass_cnt++;
   endtask

   task automatic test_pause;
      int n;
      int bad;
      mode = 2'b01; speed = 1'b1;
      @(negedge clk);
      wait_step(n);
      wait_step(n);
      total_cnt++;
      if (leds !== 4'b0100)
         $display("FAIL pause_setup leds=%b want 0100", leds);
      else pass_cnt++;
      pause = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (leds !== 4'b0100 || step !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad !== 0)
         $display("FAIL pause_hold bad_cycles=%0d want 0 leds=%b", bad, leds);
      else pass_cnt++;
      mode = 2'b11;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0000 || step !== 1'b0)
         $display("FAIL pause_mode_load leds=%b step=%b want 0000/0",
                  leds, step);
      else pass_cnt++;
      pause = 1'b0;
      wait_step(n);
      total_cnt++;
      if (n !== 3 || leds !== 4'b0001)
         $display("FAIL unpause leds=%b gap=%0d want 0001 gap 3", leds, n);
      else pass_cnt++;
   endtask

   task automatic test_collision_reset;
      int n;
      // Tick is due on the third edge after the last step; change mode
      // so it is sampled exactly on that edge.
      repeat (2) @(negedge clk);
      mode = 2'b00;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0000 || step !== 1'b0)
         $display("FAIL collision leds=%b step=%b want 0000/0", leds, step);
      else pass_cnt++;
      wait_step(n);
      total_cnt++;
      if (n !== 3 || leds !== 4'b1111)
         $display("FAIL collision_next leds=%b gap=%0d want 1111 gap 3",
                  leds, n);
      else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (leds !== 4'b0000 || step !== 1'b0)
         $display("FAIL async_reset leds=%b step=%b want 0000/0", leds, step);
      else pass_cnt++;
      mode = 2'b10;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (leds !== 4'b0001 || step !== 1'b0)
         $display("FAIL reset_reload leds=%b step=%b want 0001/0", leds, step);
      else pass_cnt++;
      wait_step(n);
      total_cnt++;
      if (n !== 3 || leds !== 4'b0010)
         $display("FAIL reset_first_step leds=%b gap=%0d want 0010 gap 3",
                  leds, n);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_chase();
      test_bounce();
      test_count();
      test_speed_switch();
      test_pause();
      test_collision_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
